life_monitor: RTL and testbench
===============================

# life_monitor

Observation stage directly downstream of the 16x16 toroidal Game of Life core. It samples the core's 256-bit `grid` every generation and reports live-cell population and generation index. It flags the three terminating conditions: still life, period-2 oscillation and extinction. Its outputs drive the status display and the run controller, which stops stepping or reloads when `done` rises.

## Interface
Parameters:
- `GEN_W`, default 16: width of the generation counter; the counter saturates at 2^GEN_W-1.

Ports:
- `clk` input 1: single clock, shared with the core.
- `reset` input 1: asynchronous, active-high.
- `load` input 1: the same load strobe the core sees; restarts monitoring.
- `grid` input 256: the core's registered grid. Bit index is 16*row+col.
- `valid` output 1: at least one sample captured since the last load/reset.
- `population` output 9: live-cell count of the most recent sample, 0..256.
- `generation` output GEN_W: generation index of the most recent sample.
- `still` output 1: the most recent sample equals the previous sample.
- `period2` output 1: the most recent sample equals the sample two back and differs from the previous sample.
- `extinct` output 1: the most recent sample has population 0.
- `done` output 1: sticky OR of `still`, `period2` and `extinct`.

## Operation
- State:
  - `prev1`/`prev2` are 256-bit history registers.
  - `hist` is a 2-bit saturating count (0, 1, 2).
  - The generation counter and output registers complete the state.
- Restart edge (load sampled 1):
  - Clear `hist`, `valid`, `still`, `period2`, `extinct`, `done`, `population` and `generation`.
  - Do not capture `grid`.
  - Holding load for several cycles keeps the block in this cleared state.
- Sample edge (load sampled 0):
  - Capture `grid` as sample S.
  - If `hist`==0, S is generation 0 and `generation`<=0; otherwise `generation`<=`generation`+1, saturating at the maximum.
  - `population`<=popcount(`grid`), a 256-input adder tree with a 9-bit result.
  - `extinct`<=(popcount==0).
  - `still`<=(`hist`>=1) && (`grid`==`prev1`).
  - `period2`<=(`hist`==2) && (`grid`==`prev2`) && (`grid`!=`prev1`).
  - `prev2`<=`prev1`, `prev1`<=`grid`, `hist`<=min(`hist`+1, 2).
  - `valid`<=1.
  - `done`<=`done` | next `extinct` | next `still` | next `period2`.
- An extinct grid also compares equal to its predecessor. `still` and `extinct` are therefore both 1 from generation 1 onward for an empty grid; at generation 0 only `extinct` is 1.
- `still` and `period2` are mutually exclusive by definition.
- Monitoring continues after `done`. The flags keep tracking each new sample, while `done` stays 1 until load or reset.
- When `generation` saturates, comparisons and population continue to update every sample.

## Timing
- Reset (asynchronous, any time, including mid-run):
  - All outputs become 0 immediately.
  - `prev1`, `prev2` and `hist` become 0.
  - The first edge after release with load=0 captures generation 0.
- Alignment:
  - The core loads `data` at edge k (load=1), so `grid`=data after edge k.
  - At edge k+1 (load=0) the monitor captures data as generation 0, and the core advances to generation 1.
  - Outputs therefore describe the grid that was present during the preceding cycle: one cycle of latency from `grid` to all outputs.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Simultaneous events:
  - Reset beats load.
  - Load beats sampling.
  - Load asserted mid-run discards all history on that edge.

## Test plan
- Blinker:
  - Stimulus: reset, then load cells 84, 85, 86 (row 5, cols 4-6), then run.
  - Gen 0: `population`=3, no flags.
  - Gen 1: `still`=0.
  - Gen 2: `period2`=1, `done`=1.
  - Gen 3: `period2`=1, `population`=3 throughout.
- Block:
  - Stimulus: load cells 0, 1, 16, 17, then run.
  - Gen 0: `still`=0, `population`=4.
  - Gen 1 onward: `still`=1, `done`=1, `period2`=0.
- Empty grid:
  - Stimulus: load all-zero data, then run.
  - Gen 0: `extinct`=1, `done`=1, `still`=0.
  - Gen 1: `still`=1 and `extinct`=1.
- Glider crossing the torus wrap:
  - Stimulus: load a glider at rows 14-15 / cols 14-15, then run 64 generations.
  - Required: `population`=5 every sample, all flags 0, `generation`=63 at the last sample.
- Reload mid-run:
  - Stimulus: run the blinker to `done`=1, then assert load for 3 cycles with block data, then run.
  - During load: all flags 0 and `valid`=0.
  - Next sample: `generation`=0, and `period2` does not re-fire from stale history.
- Reset and saturation:
  - Stimulus: GEN_W=4 with a glider, running 20 generations.
  - Required: `generation` sticks at 15.
  - Then assert reset asynchronously between edges: outputs read 0 before the next edge.

Source files
------------

// File: rtl/life_monitor.sv
// ---------------------------------------------------------------------------
// life_monitor
//
// Watches the 16x16 toroidal Game of Life grid one generation at a time and
// reports the live-cell count and the generation index of the latest sample.
// It also flags three ways a run can end:
//   - still life:  the sample repeats the previous one,
//   - period 2:    the sample repeats the one two back but not the last one,
//   - extinction:  no live cells remain.
// `done` latches any of these until the next load or reset. Monitoring keeps
// running after `done` rises, so the individual flags keep following the grid.
//
// Ports
//   clk        : clock, shared with the Life core
//   reset      : asynchronous, active-high; clears history and all outputs
//   load       : core load strobe; clears the monitor and skips capture
//   grid       : registered core grid, bit index = 16*row + col
//   valid      : at least one sample taken since the last load/reset
//   population : live-cell count of the latest sample (0..256)
//   generation : index of the latest sample; saturates at all-ones
//   still      : latest sample equals the previous sample
//   period2    : latest sample equals the sample two back, differs from last
//   extinct    : latest sample has no live cells
//   done       : sticky OR of still / period2 / extinct
//
// Every output is a register, so they describe the grid that was present
// during the previous clock cycle.
// ---------------------------------------------------------------------------
module life_monitor #(
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [255:0]     grid,
  output logic             valid,
  output logic [8:0]       population,
  output logic [GEN_W-1:0] generation,
  output logic             still,
  output logic             period2,
  output logic             extinct,
  output logic             done
);

  // How many samples are held in the history registers, saturating at two.
  typedef enum logic [1:0] {
    HIST_NONE = 2'd0,
    HIST_ONE  = 2'd1,
    HIST_TWO  = 2'd2
  } hist_t;

  localparam logic [GEN_W-1:0] GEN_MAX = '1;

  hist_t            hist_reg,       hist_next;
  logic [255:0]     prev1_reg,      prev1_next;
  logic [255:0]     prev2_reg,      prev2_next;
  logic             valid_reg,      valid_next;
  logic [8:0]       population_reg, population_next;
  logic [GEN_W-1:0] generation_reg, generation_next;
  logic             still_reg,      still_next;
  logic             period2_reg,    period2_next;
  logic             extinct_reg,    extinct_next;
  logic             done_reg,       done_next;

  // -------------------------------------------------------------------------
  // Population: balanced binary adder tree over the 256 cells. Each level
  // halves the node count and grows the sum by one bit, ending in 9 bits.
  // -------------------------------------------------------------------------
  logic [1:0] lvl1 [128];
  logic [2:0] lvl2 [64];
  logic [3:0] lvl3 [32];
  logic [4:0] lvl4 [16];
  logic [5:0] lvl5 [8];
  logic [6:0] lvl6 [4];
  logic [7:0] lvl7 [2];
  logic [8:0] pop_sum;

  for (genvar gi = 0; gi < 128; gi++) begin : g_lvl1
    assign lvl1[gi] = {1'b0, grid[2*gi]} + {1'b0, grid[2*gi+1]};
  end

  for (genvar gi = 0; gi < 64; gi++) begin : g_lvl2
    assign lvl2[gi] = {1'b0, lvl1[2*gi]} + {1'b0, lvl1[2*gi+1]};
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_lvl3
    assign lvl3[gi] = {1'b0, lvl2[2*gi]} + {1'b0, lvl2[2*gi+1]};
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_lvl4
    assign lvl4[gi] = {1'b0, lvl3[2*gi]} + {1'b0, lvl3[2*gi+1]};
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lvl5
    assign lvl5[gi] = {1'b0, lvl4[2*gi]} + {1'b0, lvl4[2*gi+1]};
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lvl6
    assign lvl6[gi] = {1'b0, lvl5[2*gi]} + {1'b0, lvl5[2*gi+1]};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lvl7
    assign lvl7[gi] = {1'b0, lvl6[2*gi]} + {1'b0, lvl6[2*gi+1]};
  end

  assign pop_sum = {1'b0, lvl7[0]} + {1'b0, lvl7[1]};

  // -------------------------------------------------------------------------
  // History comparisons against the incoming grid.
  // -------------------------------------------------------------------------
  logic same_as_prev1;
  logic same_as_prev2;

  assign same_as_prev1 = (grid == prev1_reg);
  assign same_as_prev2 = (grid == prev2_reg);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    hist_next       = hist_reg;
    prev1_next      = prev1_reg;
    prev2_next      = prev2_reg;
    valid_next      = valid_reg;
    population_next = population_reg;
    generation_next = generation_reg;
    still_next      = still_reg;
    period2_next    = period2_reg;
    extinct_next    = extinct_reg;
    done_next       = done_reg;

    if (load) begin
      // Restart: forget history so stale samples from before the load can
      // never match the new pattern. prev1/prev2 may keep old contents; an
      // empty hist makes them irrelevant.
      hist_next       = HIST_NONE;
      valid_next      = 1'b0;
      population_next = '0;
      generation_next = '0;
      still_next      = 1'b0;
      period2_next    = 1'b0;
      extinct_next    = 1'b0;
      done_next       = 1'b0;
    end else begin
      valid_next      = 1'b1;
      population_next = pop_sum;
      extinct_next    = (pop_sum == 9'd0);
      still_next      = (hist_reg != HIST_NONE) && same_as_prev1;
      period2_next    = (hist_reg == HIST_TWO) && same_as_prev2 && !same_as_prev1;
      done_next       = done_reg | extinct_next | still_next | period2_next;

      // First sample after a restart is generation 0; later ones count up
      // and stick at the maximum.
      if (hist_reg == HIST_NONE) begin
        generation_next = '0;
      end else if (generation_reg != GEN_MAX) begin
        generation_next = generation_reg + 1'b1;
      end

      prev2_next = prev1_reg;
      prev1_next = grid;

      unique case (hist_reg)
        HIST_NONE: hist_next = HIST_ONE;
        HIST_ONE:  hist_next = HIST_TWO;
        default:   hist_next = HIST_TWO;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg       <= HIST_NONE;
      prev1_reg      <= '0;
      prev2_reg      <= '0;
      valid_reg      <= 1'b0;
      population_reg <= '0;
      generation_reg <= '0;
      still_reg      <= 1'b0;
      period2_reg    <= 1'b0;
      extinct_reg    <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      hist_reg       <= hist_next;
      prev1_reg      <= prev1_next;
      prev2_reg      <= prev2_next;
      valid_reg      <= valid_next;
      population_reg <= population_next;
      generation_reg <= generation_next;
      still_reg      <= still_next;
      period2_reg    <= period2_next;
      extinct_reg    <= extinct_next;
      done_reg       <= done_next;
    end
  end

  assign valid      = valid_reg;
  assign population = population_reg;
  assign generation = generation_reg;
  assign still      = still_reg;
  assign period2    = period2_reg;
  assign extinct    = extinct_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_life_monitor.sv
// ---------------------------------------------------------------------------
// tb_life_monitor
//
// Directed bench for life_monitor. The bench plays the role of the Life core:
// it holds the grid and advances it with a small reference Life step after
// every sampling edge. Two monitors share all inputs: one with the default
// 16-bit generation counter and one with a 4-bit counter for saturation.
// ---------------------------------------------------------------------------
module tb_life_monitor;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [255:0] grid;

  logic         valid,   valid4;
  logic [8:0]   population, population4;
  logic [15:0]  generation;
  logic [3:0]   generation4;
  logic         still,   still4;
  logic         period2, period24;
  logic         extinct, extinct4;
  logic         done,    done4;

  int tests  = 0;
  int failed = 0;

  logic [255:0] blinker;
  logic [255:0] block;
  logic [255:0] glider;

  always #5 clk = ~clk;

  life_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .grid       (grid),
    .valid      (valid),
    .population (population),
    .generation (generation),
    .still      (still),
    .period2    (period2),
    .extinct    (extinct),
    .done       (done)
  );

  life_monitor #(.GEN_W(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .grid       (grid),
    .valid      (valid4),
    .population (population4),
    .generation (generation4),
    .still      (still4),
    .period2    (period24),
    .extinct    (extinct4),
    .done       (done4)
  );

  // Reference toroidal Life step, used only to produce the core's grid.
  function automatic logic [255:0] life_step(input logic [255:0] g);
    logic [255:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              cnt += int'(g[((r + dr + 16) % 16) * 16 + ((c + dc + 16) % 16)]);
            end
          end
        end
        n[r*16 + c] = (cnt == 3) || (cnt == 2 && g[r*16 + c]);
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks every output of the default-width monitor in one go.
  task automatic check_all(input string tag, input logic v, input int pop, input int gen,
                           input logic s, input logic p2, input logic ex, input logic dn);
    check({tag, ".valid"},      32'(valid),      32'(v));
    check({tag, ".population"}, 32'(population), 32'(pop));
    check({tag, ".generation"}, 32'(generation), 32'(gen));
    check({tag, ".still"},      32'(still),      32'(s));
    check({tag, ".period2"},    32'(period2),    32'(p2));
    check({tag, ".extinct"},    32'(extinct),    32'(ex));
    check({tag, ".done"},       32'(done),       32'(dn));
  endtask

  initial begin
    blinker = '0;
    blinker[84] = 1'b1; blinker[85] = 1'b1; blinker[86] = 1'b1;
    block = '0;
    block[0] = 1'b1; block[1] = 1'b1; block[16] = 1'b1; block[17] = 1'b1;
    // Glider anchored at row 14, col 14, wrapping past both edges:
    // cells (14,15) (15,0) (0,14) (0,15) (0,0).
    glider = '0;
    glider[14*16 + 15] = 1'b1;
    glider[15*16 + 0]  = 1'b1;
    glider[0*16 + 14]  = 1'b1;
    glider[0*16 + 15]  = 1'b1;
    glider[0*16 + 0]   = 1'b1;

    // ---- Reset state ----
    reset = 1'b1;
    load  = 1'b1;
    grid  = '0;
    #1;
    check_all("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();  // restart edge
    check("load0.valid", 32'(valid), 32'd0);

    // ---- Blinker ----
    grid = blinker;
    load = 1'b0;
    tick(); check_all("blink_g0", 1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    grid = life_step(grid);
    tick(); check_all("blink_g1", 1'b1, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    grid = life_step(grid);
    tick(); check_all("blink_g2", 1'b1, 3, 2, 1'b0, 1'b1, 1'b0, 1'b1);
    grid = life_step(grid);
    tick(); check_all("blink_g3", 1'b1, 3, 3, 1'b0, 1'b1, 1'b0, 1'b1);
    grid = life_step(grid);

    // ---- Reload mid-run with block, load held three cycles ----
    load = 1'b1;
    tick(); check_all("reload_c0", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    grid = block;
    tick(); check_all("reload_c1", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check_all("reload_c2", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    tick(); check_all("block_g0", 1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    grid = life_step(grid);
    tick(); check_all("block_g1", 1'b1, 4, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    grid = life_step(grid);
    tick(); check_all("block_g2", 1'b1, 4, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    grid = life_step(grid);

    // ---- Reload the same block: history must not make it look still ----
    load = 1'b1;
    tick(); check("stale_load.done", 32'(done), 32'd0);
    load = 1'b0;
    tick(); check_all("stale_g0", 1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    grid = life_step(grid);

    // ---- Empty grid ----
    load = 1'b1;
    tick();
    grid = '0;
    load = 1'b0;
    tick(); check_all("empty_g0", 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    grid = life_step(grid);
    tick(); check_all("empty_g1", 1'b1, 0, 1, 1'b1, 1'b0, 1'b1, 1'b1);
    grid = life_step(grid);

    // ---- Glider across the wrap; 4-bit counter saturates ----
    load = 1'b1;
    tick();
    grid = glider;
    load = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      check("glider.population", 32'(population), 32'd5);
      check("glider.flags", {28'd0, still, period2, extinct, done}, 32'd0);
      check("glider.generation", 32'(generation), 32'(i));
      check("glider.generation4", 32'(generation4), (i > 15) ? 32'd15 : 32'(i));
      check("glider.population4", 32'(population4), 32'd5);
      grid = life_step(grid);
    end
    check("glider.last_gen", 32'(generation), 32'd63);

    // ---- Asynchronous reset between edges ----
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("async_rst.valid4",      32'(valid4),      32'd0);
    check("async_rst.population4", 32'(population4), 32'd0);
    check("async_rst.generation4", 32'(generation4), 32'd0);
    check("async_rst.flags4", {28'd0, still4, period24, extinct4, done4}, 32'd0);

    // First edge after release with load low captures generation 0.
    @(negedge clk);
    reset = 1'b0;
    grid  = glider;
    load  = 1'b0;
    tick(); check_all("post_rst_g0", 1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
